fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of ID-stage hazard detection.

---
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with IF/ID pipeline register, a
//               one-word hold buffer for stalled returns, redirect and HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               STALL,
    input  logic               redirect_en,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] instr_ID,
    output logic [PC_W-1:0]    pc2_ID,
    output logic               valid_ID,
    output logic               halted
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [4:0] c_HALT_OPCODE = 5'b00000;

    logic [1:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc2;
    logic               r_valid;
    logic [INSTR_W-1:0] r_hold_buf;

    logic [PC_W-1:0]    w_pc_plus2;
    logic               w_rdata_is_halt;
    logic               w_buf_is_halt;

    // Wraps naturally at 2^PC_W.
    assign w_pc_plus2      = r_pc + PC_W'(2);
    assign w_rdata_is_halt = (imem_rdata[INSTR_W-1 -: 5] == c_HALT_OPCODE);
    assign w_buf_is_halt   = (r_hold_buf[INSTR_W-1 -: 5] == c_HALT_OPCODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc2      <= '0;
            r_valid    <= 1'b0;
            r_hold_buf <= '0;
        end else if (redirect_en) begin
            // Squash wins over STALL and over any returned or buffered word.
            r_state    <= S_FETCH;
            r_pc       <= redirect_pc;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
            r_hold_buf <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        if (STALL) begin
                            r_hold_buf <= imem_rdata;
                            r_state    <= S_HOLD;
                        end else begin
                            r_instr <= imem_rdata;
                            r_pc2   <= w_pc_plus2;
                            r_valid <= 1'b1;
                            r_pc    <= w_pc_plus2;
                            r_state <= w_rdata_is_halt ? S_HALTED : S_FETCH;
                        end
                    end
                end
                S_HOLD: begin
                    if (!STALL) begin
                        r_instr <= r_hold_buf;
                        r_pc2   <= w_pc_plus2;
                        r_valid <= 1'b1;
                        r_pc    <= w_pc_plus2;
                        r_state <= w_buf_is_halt ? S_HALTED : S_FETCH;
                    end
                end
                S_HALTED: begin
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign instr_ID  = r_instr;
    assign pc2_ID    = r_pc2;
    assign valid_ID  = r_valid;
    assign halted    = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed and randomized bench for fetch_stage with a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int          c_PC_W    = 16;
    localparam int          c_INSTR_W = 16;
    localparam logic [15:0] c_NOP     = 16'h0800;

    logic        clk;
    logic        rst_n;
    logic        STALL;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] instr_ID;
    logic [15:0] pc2_ID;
    logic        valid_ID;
    logic        halted;

    int n_cmp;
    int n_err;

    // Reference model: architectural view of the stage.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pc2;
    logic        m_valid;
    logic        m_have_buf;
    logic [15:0] m_buf;
    logic        m_halted;

    fetch_stage #(
        .PC_W     (c_PC_W),
        .INSTR_W  (c_INSTR_W),
        .RESET_PC (16'h0000),
        .NOP_INSTR(c_NOP)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .STALL      (STALL),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .instr_ID   (instr_ID),
        .pc2_ID     (pc2_ID),
        .valid_ID   (valid_ID),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = c_NOP; m_pc2 = 16'h0000; m_valid = 1'b0;
        m_have_buf = 1'b0; m_buf = 16'h0000; m_halted = 1'b0;
    endtask

    task automatic model_accept(input logic [15:0] word);
        m_instr  = word;
        m_valid  = 1'b1;
        m_pc2    = 16'((32'(m_pc) + 2) % 65536);
        m_pc     = m_pc2;
        m_halted = (word[15:11] == 5'd0);
    endtask

    task automatic model_step();
        if (redirect_en) begin
            m_instr = c_NOP; m_valid = 1'b0; m_pc = redirect_pc;
            m_have_buf = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
        end else if (m_have_buf) begin
            if (!STALL) begin
                m_have_buf = 1'b0;
                model_accept(m_buf);
            end
        end else if (imem_ready) begin
            if (STALL) begin
                m_buf = imem_rdata; m_have_buf = 1'b1;
            end else begin
                model_accept(imem_rdata);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic st, input logic rdy, input logic [15:0] data);
        STALL = st; imem_ready = rdy; imem_rdata = data;
        redirect_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);
        redirect_pc = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (instr_ID !== 16'h0800) begin n_err++; $display("FAIL reset_instr got=%h exp=%h", instr_ID, 16'h0800); end
        n_cmp++;
        if (valid_ID !== 1'b0 || pc2_ID !== 16'h0000) begin n_err++; $display("FAIL reset_valid_pc2 got=%b/%h exp=0/0000", valid_ID, pc2_ID); end
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || halted !== 1'b0) begin
            n_err++; $display("FAIL reset_req got req=%b addr=%h halted=%b exp=1/0000/0", imem_req, imem_addr, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_straight_line();
        logic [15:0] words [3];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, words[i]);
            cycle();
            n_cmp++;
            if (instr_ID !== words[i] || pc2_ID !== 16'(2 * (i + 1)) || valid_ID !== 1'b1) begin
                n_err++;
                $display("FAIL straight_%0d got=%h/%h/%b exp=%h/%h/1", i, instr_ID, pc2_ID, valid_ID, words[i], 16'(2 * (i + 1)));
            end
        end
    endtask

    task automatic test_stall_hold();
        drive(1'b1, 1'b1, 16'h4444);
        cycle();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (instr_ID !== 16'h3333 || imem_req !== 1'b0 || imem_addr !== 16'h0006) begin
                n_err++;
                $display("FAIL stall_hold_%0d got=%h req=%b addr=%h exp=3333/0/0006", i, instr_ID, imem_req, imem_addr);
            end
            if (i < 2) begin
                drive(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
                cycle();
            end
        end
        drive(1'b0, 1'b0, 16'h0000);
        cycle();
        n_cmp++;
        if (instr_ID !== 16'h4444 || pc2_ID !== 16'h0008 || imem_addr !== 16'h0008 || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release got=%h/%h addr=%h req=%b exp=4444/0008/0008/1", instr_ID, pc2_ID, imem_addr, imem_req);
        end
    endtask

    task automatic test_redirect_hold();
        drive(1'b1, 1'b1, 16'h5555);
        cycle();
        drive(1'b1, 1'b1, 16'h9999);
        redirect_en = 1'b1; redirect_pc = 16'h0040;
        cycle();
        n_cmp++;
        if (instr_ID !== 16'h0800 || valid_ID !== 1'b0 || imem_addr !== 16'h0040 || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL redirect_hold got=%h v=%b addr=%h req=%b exp=0800/0/0040/1", instr_ID, valid_ID, imem_addr, imem_req);
        end
        drive(1'b0, 1'b1, 16'h6666);
        cycle();
        n_cmp++;
        if (instr_ID !== 16'h6666 || pc2_ID !== 16'h0042 || valid_ID !== 1'b1) begin
            n_err++;
            $display("FAIL redirect_refetch got=%h/%h v=%b exp=6666/0042/1", instr_ID, pc2_ID, valid_ID);
        end
    endtask

    task automatic test_halt();
        drive(1'b0, 1'b1, 16'h0000);
        cycle();
        n_cmp++;
        if (instr_ID !== 16'h0000 || halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 16'h0044) begin
            n_err++;
            $display("FAIL halt_enter got=%h h=%b req=%b addr=%h exp=0000/1/0/0044", instr_ID, halted, imem_req, imem_addr);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            cycle();
        end
        n_cmp++;
        if (imem_addr !== 16'h0044 || instr_ID !== 16'h0000 || halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_frozen got addr=%h instr=%h h=%b exp=0044/0000/1", imem_addr, instr_ID, halted);
        end
        drive(1'b0, 1'b0, 16'h0000);
        redirect_en = 1'b1; redirect_pc = 16'h0010;
        cycle();
        n_cmp++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
            n_err++;
            $display("FAIL halt_resume got h=%b req=%b addr=%h exp=0/1/0010", halted, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 16'h0000);
        redirect_en = 1'b1; redirect_pc = 16'hFFFE;
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 16'($urandom));
            cycle();
            n_cmp++;
            if (imem_addr !== 16'hFFFE || imem_req !== 1'b1 || valid_ID !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_wait_%0d got addr=%h req=%b v=%b exp=FFFE/1/0", i, imem_addr, imem_req, valid_ID);
            end
        end
        drive(1'b0, 1'b1, 16'h7777);
        cycle();
        n_cmp++;
        if (pc2_ID !== 16'h0000 || imem_addr !== 16'h0000 || instr_ID !== 16'h7777) begin
            n_err++;
            $display("FAIL wrap_accept got pc2=%h addr=%h instr=%h exp=0000/0000/7777", pc2_ID, imem_addr, instr_ID);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 16'h1234);
        cycle();
        drive(1'b0, 1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (instr_ID !== c_NOP || valid_ID !== 1'b0 || pc2_ID !== 16'h0000 || imem_addr !== 16'h0000 || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset got instr=%h v=%b pc2=%h addr=%h req=%b exp=0800/0/0000/0000/1",
                     instr_ID, valid_ID, pc2_ID, imem_addr, imem_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [15:0] data;
        for (int i = 0; i < 400; i++) begin
            data = 16'($urandom);
            if ($urandom_range(0, 15) == 0) data[15:11] = 5'd0;
            drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), data);
            redirect_en = 1'($urandom_range(0, 9) == 0);
            redirect_pc = 16'($urandom) & 16'hFFFE;
            cycle();
            n_cmp++;
            if (instr_ID !== m_instr || pc2_ID !== m_pc2 || valid_ID !== m_valid) begin
                n_err++;
                $display("FAIL random_ifid_%0d got=%h/%h/%b exp=%h/%h/%b", i, instr_ID, pc2_ID, valid_ID, m_instr, m_pc2, m_valid);
            end
            n_cmp++;
            if (imem_addr !== m_pc || imem_req !== (!m_halted && !m_have_buf) || halted !== m_halted) begin
                n_err++;
                $display("FAIL random_ctrl_%0d got addr=%h req=%b h=%b exp=%h/%b/%b", i, imem_addr, imem_req, halted,
                         m_pc, !m_halted && !m_have_buf, m_halted);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_straight_line();
        test_stall_hold();
        test_redirect_hold();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
